// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction-memory and IR handshake bundle for the fetch unit
interface instr_fetch_unit_if #(
    parameter int unsigned AW = 8
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          ir_valid;
    logic          ir_ready;
    logic [31:0]   ir;
    logic [AW-1:0] ir_pc;

    modport master (
        output imem_req, imem_addr, ir_valid, ir, ir_pc,
        input  imem_rvalid, imem_rdata, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, ir, ir_pc,
        output imem_rvalid, imem_rdata, ir_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder that fetches one instruction at a time into the execute IR
module instr_fetch_unit #(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [4:0]    HALT_OP  = 5'b11111,
    parameter int unsigned   CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 start,
    instr_fetch_unit_if.master   bus,
    input  logic                 redirect,
    input  logic [AW-1:0]        redirect_pc,
    output logic [AW-1:0]        pc,
    output logic                 halted,
    output logic [CNT_W-1:0]     issued_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP,
        ST_ISSUE,
        ST_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             imem_req_q, imem_req_d;
    logic [AW-1:0]    imem_addr_q, imem_addr_d;
    logic             ir_valid_q, ir_valid_d;
    logic [31:0]      ir_q, ir_d;
    logic [AW-1:0]    ir_pc_q, ir_pc_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            ir_valid_q  <= 1'b0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            halted_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            ir_valid_q  <= ir_valid_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            halted_q    <= halted_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_valid_d = ir_valid_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        halted_d   = halted_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_REQ;
            end
            ST_REQ: begin
                // The request for the old pc is already on the bus; its response must be dropped.
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ir_valid_d = 1'b0;
                    state_d    = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ir_valid_d = 1'b0;
                    state_d    = bus.imem_rvalid ? ST_REQ : ST_DROP;
                end else if (bus.imem_rvalid) begin
                    if (bus.imem_rdata[31:27] == HALT_OP) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        ir_d       = bus.imem_rdata;
                        ir_pc_d    = pc_q;
                        pc_d       = pc_q + 1'b1;
                        ir_valid_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_DROP: begin
                if (redirect) pc_d = redirect_pc;
                if (bus.imem_rvalid) state_d = ST_REQ;
            end
            ST_ISSUE: begin
                // A transfer that coincides with a redirect was still consumed, so it is counted.
                if (ir_valid_q && bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = ST_REQ;
                end
                if (redirect) begin
                    pc_d       = redirect_pc;
                    ir_valid_d = 1'b0;
                    state_d    = ST_REQ;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        imem_req_d  = (state_d == ST_REQ);
        imem_addr_d = imem_req_d ? pc_d : imem_addr_q;
    end

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.ir_valid  = ir_valid_q;
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    assign pc            = pc_q;
    assign halted        = halted_q;
    assign issued_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench for instr_fetch_unit with a latency-programmable memory
module tb_instr_fetch_unit;
    localparam int AW    = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             sys_rst;
    logic             start;
    logic             redirect;
    logic [AW-1:0]    redirect_pc;
    logic [AW-1:0]    pc;
    logic             halted;
    logic [CNT_W-1:0] issued_cnt;

    instr_fetch_unit_if #(.AW(AW)) bus ();

    instr_fetch_unit #(
        .AW       (AW),
        .RESET_PC (8'h00),
        .HALT_OP  (5'b11111),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .bus         (bus.master),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .halted      (halted),
        .issued_cnt  (issued_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          mem_lat;
    int          nvec;
    int          nerr;
    int          exp_cnt;

    // Memory: one outstanding request, response presented mem_lat cycles after the request cycle.
    initial begin
        logic       pending;
        int         left;
        logic [7:0] p_addr;
        pending         = 1'b0;
        left            = 0;
        p_addr          = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (pending) begin
                left = left - 1;
                if (left == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem[p_addr];
                    pending         = 1'b0;
                end
            end
            if (bus.imem_req === 1'b1) begin
                pending = 1'b1;
                left    = mem_lat;
                p_addr  = bus.imem_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input int a);
        chk("seq_req", 32'(bus.imem_req), 32'd1);
        chk("seq_addr", 32'(bus.imem_addr), 32'(a));
        tick();
        chk("seq_wait_ir_valid", 32'(bus.ir_valid), 32'd0);
        tick();
        chk("seq_ir_valid", 32'(bus.ir_valid), 32'd1);
        chk("seq_ir", bus.ir, mem[a]);
        chk("seq_ir_pc", 32'(bus.ir_pc), 32'(a));
        chk("seq_pc", 32'(pc), 32'((a + 1) % 256));
        tick();
        exp_cnt++;
        chk("seq_ir_valid_clr", 32'(bus.ir_valid), 32'd0);
        chk("seq_cnt", 32'(issued_cnt), 32'(exp_cnt));
    endtask

    initial begin
        nvec         = 0;
        nerr         = 0;
        exp_cnt      = 0;
        mem_lat      = 1;
        sys_rst      = 1'b1;
        start        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;
        bus.ir_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1800_0000 | 32'(i);
        mem[0] = 32'h0842_2000;
        mem[1] = 32'h1081_0005;
        mem[2] = 32'h0863_1800;
        mem[3] = 32'h10C1_0007;

        tick();
        tick();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'h0);
        chk("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("rst_ir", bus.ir, 32'h0);
        chk("rst_ir_pc", 32'(bus.ir_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(issued_cnt), 32'd0);
        sys_rst = 1'b0;
        tick();
        chk("idle_no_req", 32'(bus.imem_req), 32'd0);

        // Sequential fetch, 1-cycle memory, execute always ready
        bus.ir_ready = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        for (int a = 0; a < 4; a++) run_one(a);

        // Backpressure on the instruction at address 4
        bus.ir_ready = 1'b0;
        chk("bp_req", 32'(bus.imem_req), 32'd1);
        chk("bp_addr", 32'(bus.imem_addr), 32'h4);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_ir_valid", 32'(bus.ir_valid), 32'd1);
            chk("bp_ir", bus.ir, mem[4]);
            chk("bp_ir_pc", 32'(bus.ir_pc), 32'h4);
            chk("bp_no_req", 32'(bus.imem_req), 32'd0);
            chk("bp_cnt", 32'(issued_cnt), 32'd4);
            tick();
        end
        bus.ir_ready = 1'b1;
        mem_lat      = 3;
        tick();
        chk("bp_release_cnt", 32'(issued_cnt), 32'd5);
        chk("bp_release_ir_valid", 32'(bus.ir_valid), 32'd0);

        // Redirect one cycle after the request at 0x05, 3-cycle memory
        chk("rw_req", 32'(bus.imem_req), 32'd1);
        chk("rw_addr", 32'(bus.imem_addr), 32'h5);
        tick();
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        tick();
        redirect = 1'b0;
        chk("rw_pc", 32'(pc), 32'h40);
        chk("rw_drop_no_req", 32'(bus.imem_req), 32'd0);
        chk("rw_drop_ir_valid", 32'(bus.ir_valid), 32'd0);
        tick();
        chk("rw_stale_no_req", 32'(bus.imem_req), 32'd0);
        chk("rw_stale_ir_valid", 32'(bus.ir_valid), 32'd0);
        tick();
        chk("rw_new_req", 32'(bus.imem_req), 32'd1);
        chk("rw_new_addr", 32'(bus.imem_addr), 32'h40);
        chk("rw_new_ir_valid", 32'(bus.ir_valid), 32'd0);
        repeat (3) tick();
        chk("rw_wait_ir_valid", 32'(bus.ir_valid), 32'd0);
        tick();
        chk("rw_ir_valid", 32'(bus.ir_valid), 32'd1);
        chk("rw_ir", bus.ir, mem[8'h40]);
        chk("rw_ir_pc", 32'(bus.ir_pc), 32'h40);

        // Redirect coinciding with the IR handshake
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        tick();
        redirect = 1'b0;
        chk("rh_cnt", 32'(issued_cnt), 32'd6);
        chk("rh_req", 32'(bus.imem_req), 32'd1);
        chk("rh_addr", 32'(bus.imem_addr), 32'h80);
        chk("rh_pc", 32'(pc), 32'h80);
        chk("rh_ir_valid", 32'(bus.ir_valid), 32'd0);

        // Asynchronous reset while waiting on the 0x80 response
        tick();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("ar_pc", 32'(pc), 32'h0);
        chk("ar_addr", 32'(bus.imem_addr), 32'h0);
        chk("ar_cnt", 32'(issued_cnt), 32'd0);
        chk("ar_ir", bus.ir, 32'h0);
        chk("ar_ir_pc", 32'(bus.ir_pc), 32'h0);
        chk("ar_ir_valid", 32'(bus.ir_valid), 32'd0);
        @(posedge clk);
        #2;
        sys_rst = 1'b0;
        tick();
        tick();
        chk("ar_late_no_req", 32'(bus.imem_req), 32'd0);
        chk("ar_late_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("ar_late_pc", 32'(pc), 32'h0);
        chk("ar_late_ir", bus.ir, 32'h0);
        tick();
        chk("ar_idle_no_req", 32'(bus.imem_req), 32'd0);

        // HALT word at address 2
        mem[2]  = 32'hF800_0000;
        mem_lat = 1;
        exp_cnt = 0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        run_one(0);
        run_one(1);
        chk("h_req", 32'(bus.imem_req), 32'd1);
        chk("h_addr", 32'(bus.imem_addr), 32'h2);
        tick();
        tick();
        chk("h_halted", 32'(halted), 32'd1);
        chk("h_pc", 32'(pc), 32'h2);
        chk("h_ir_valid", 32'(bus.ir_valid), 32'd0);
        chk("h_no_req", 32'(bus.imem_req), 32'd0);
        chk("h_cnt", 32'(issued_cnt), 32'd2);
        start       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h33;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("h_stuck_halted", 32'(halted), 32'd1);
            chk("h_stuck_pc", 32'(pc), 32'h2);
            chk("h_stuck_no_req", 32'(bus.imem_req), 32'd0);
        end
        start    = 1'b0;
        redirect = 1'b0;
        #2;
        sys_rst = 1'b1;
        #1;
        chk("h_rst_halted", 32'(halted), 32'd0);
        chk("h_rst_pc", 32'(pc), 32'h0);
        @(posedge clk);
        #2;
        sys_rst = 1'b0;
        tick();
        chk("h_rst_idle_no_req", 32'(bus.imem_req), 32'd0);
        chk("h_rst_idle_halted", 32'(halted), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
